fetch_ctrl: RTL

Fetch sequencer for the IF stage. It owns the program counter and drives a request/ready handshake to a variable-latency instruction memory. It arbitrates next-PC sources (jump, branch, sequential), honours the hazard-unit stall, and generates the IF/ID flush. It replaces the free-running PC/adder/mux chain with a controlled fetch loop.

---
 rtl/fetch_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl -- IF-stage fetch sequencer
//
// Owns the program counter and runs a request/ready fetch loop against a
// variable-latency instruction memory. Selects the next PC from jump, branch
// or sequential sources, honours the hazard-unit stall, and raises a
// one-cycle IF/ID flush whenever the fetch stream is redirected.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   PC_STEP   sequential increment in bytes
//   CNT_W     performance counter width (only with FETCH_COUNT_EN)
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   stall                hazard-unit hold, freezes PC and fetch output
//   jump_ctrl/_address   jump request and target (highest priority)
//   branch_ctrl/_address branch request and target
//   imem_req/imem_addr   fetch request and address (address is always pc)
//   imem_ready/_rdata    memory response for the current request
//   pc                   PC of the current fetch
//   instr/instr_valid    registered instruction to IF/ID and its valid flag
//   flush                one-cycle IF/ID flush on redirect
//
// Optional build macro FETCH_COUNT_EN adds fetch_count (accepted, kept
// fetches) and stall_count (cycles spent in WAIT or HOLD).
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
`ifdef FETCH_COUNT_EN
    ,
    parameter int unsigned CNT_W    = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_ctrl,
    input  logic [31:0]      branch_address,
    input  logic             jump_ctrl,
    input  logic [31:0]      jump_address,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             flush
`ifdef FETCH_COUNT_EN
    ,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;

    logic        redirect;
    logic [31:0] redirect_tgt;
    logic [31:0] next_pc;
    logic        take_fetch;

    // Jump outranks branch when both fire in the same cycle.
    assign redirect     = jump_ctrl | branch_ctrl;
    assign redirect_tgt = jump_ctrl ? jump_address : branch_address;
    // Natural 32-bit wrap: the top word steps back to address 0.
    assign next_pc      = pc_q + STEP;

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        flush_d    = redirect;
        take_fetch = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect) begin
                    pc_d = redirect_tgt;
                end
            end

            S_REQ: begin
                if (redirect) begin
                    // A fetch landing this same cycle belongs to the old
                    // stream and is dropped.
                    pc_d    = redirect_tgt;
                    valid_d = 1'b0;
                end else if (imem_ready) begin
                    take_fetch = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                // The address must stay stable until memory answers, so a
                // redirect is only remembered here; the newest one wins.
                if (redirect) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = redirect_tgt;
                end
                if (imem_ready) begin
                    if (redirect || pend_q) begin
                        pc_d    = redirect ? redirect_tgt : pend_tgt_q;
                        valid_d = 1'b0;
                        pend_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        take_fetch = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_tgt;
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end else if (!stall) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Shared accept path for REQ and WAIT: capture the word, then either
        // advance or park in HOLD while the hazard unit stalls.
        if (take_fetch) begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
            if (stall) begin
                state_d = S_HOLD;
            end else begin
                pc_d    = next_pc;
                state_d = S_REQ;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            flush_q    <= flush_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign imem_req    = (state_q == S_REQ) || (state_q == S_WAIT);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign flush       = flush_q;

`ifdef FETCH_COUNT_EN
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (take_fetch) begin
                fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
            end
            if ((state_q == S_WAIT) || (state_q == S_HOLD)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule
